// File: rtl/kp_collect.sv
// Keypoint collector: tags flagged DoG extremes with raster x/y/octave and queues them in a FWFT FIFO.
// Optional contrast threshold on push is enabled by defining KP_THR_EN.
module kp_collect #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int DEPTH = 16,
    parameter int THR   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       octave,
    input  logic                       pix_vld,
    input  logic                       kp_flag,
    input  logic [7:0]                 kp_max,
    input  logic [7:0]                 kp_min,
    input  logic                       kp_ready,
    output logic                       kp_valid,
    output logic [8:0]                 kp_x,
    output logic [8:0]                 kp_y,
    output logic                       kp_oct,
    output logic [7:0]                 kp_vmax,
    output logic [7:0]                 kp_vmin,
    output logic [$clog2(DEPTH):0]     fifo_lvl,
    output logic [15:0]                kp_cnt,
    output logic                       overflow,
    output logic                       frame_done,
    output logic [1:0]                 fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 35;

    localparam logic [8:0] X_LAST0 = 9'(IMG_W - 1);
    localparam logic [8:0] X_LAST1 = 9'((IMG_W >> 1) - 1);
    localparam logic [8:0] Y_LAST0 = 9'(IMG_H - 1);
    localparam logic [8:0] Y_LAST1 = 9'((IMG_H >> 1) - 1);
    localparam logic [7:0] THR_S   = 8'(THR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           oct_r;
    logic [8:0]     x;
    logic [8:0]     y;
    logic [8:0]     x_last;
    logic [8:0]     y_last;

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    lvl;
    logic [AW:0]    lvl_next;
    logic [AW-1:0]  rd_idx_next;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  head;
    logic [EW-1:0]  head_next;
    logic [EW-1:0]  din;

    logic           thr_ok;
    logic           push_req;
    logic           push;
    logic           pop;
    logic           full;

    assign x_last = oct_r ? X_LAST1 : X_LAST0;
    assign y_last = oct_r ? Y_LAST1 : Y_LAST0;

`ifdef KP_THR_EN
    always_comb begin
        thr_ok = ($signed(kp_max) > $signed(THR_S)) || ($signed(kp_min) < -$signed(THR_S));
    end
`else
    // THR is a 7-bit magnitude, so this is constant 1: every flagged pixel passes.
    always_comb begin
        thr_ok = (THR_S[7] == 1'b0);
    end
`endif

    // A frame_start cycle belongs to the new frame's setup, not to any pixel.
    assign push_req    = pix_vld && kp_flag && (state == SCAN) && !frame_start && thr_ok;
    assign lvl         = wr_ptr - rd_ptr;
    assign full        = (lvl == (AW+1)'(DEPTH));
    assign pop         = kp_valid && kp_ready;
    assign push        = push_req && (!full || pop);
    assign din         = {x, y, oct_r, kp_max, kp_min};
    assign lvl_next    = lvl + (AW+1)'(push) - (AW+1)'(pop);
    assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);

    // The head register must show whatever sits at the read pointer after this edge.
    always_comb begin
        head_next = head;
        if (pop) begin
            if (lvl == (AW+1)'(1)) begin
                if (push) head_next = din;
            end else begin
                head_next = mem[rd_idx_next];
            end
        end else if ((lvl == '0) && push) begin
            head_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head     <= '0;
            kp_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            head     <= head_next;
            kp_valid <= (lvl_next != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kp_cnt   <= '0;
            overflow <= 1'b0;
        end else if (frame_start) begin
            kp_cnt   <= '0;
            overflow <= 1'b0;
        end else if (push_req) begin
            if (push) begin
                if (kp_cnt != 16'hFFFF) kp_cnt <= kp_cnt + 16'd1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            oct_r      <= 1'b0;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                state <= SCAN;
                oct_r <= octave;
                x     <= '0;
                y     <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    SCAN: begin
                        if (pix_vld) begin
                            if (x == x_last) begin
                                x <= '0;
                                if (y == y_last) begin
                                    y          <= '0;
                                    state      <= DONE;
                                    frame_done <= 1'b1;
                                end else begin
                                    y <= y + 9'd1;
                                end
                            end else begin
                                x <= x + 9'd1;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign {kp_x, kp_y, kp_oct, kp_vmax, kp_vmin} = head;
    assign fifo_lvl  = lvl;
    assign fsm_state = state;

endmodule

// File: tb/tb_kp_collect.sv
// Directed bench for kp_collect: reset, raster tagging, overflow, full+pop, backpressure, threshold.
module tb_kp_collect;

    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        octave;
    logic        pix_vld;
    logic        kp_flag;
    logic [7:0]  kp_max;
    logic [7:0]  kp_min;
    logic        kp_ready;
    logic        kp_valid;
    logic [8:0]  kp_x;
    logic [8:0]  kp_y;
    logic        kp_oct;
    logic [7:0]  kp_vmax;
    logic [7:0]  kp_vmin;
    logic [4:0]  fifo_lvl;
    logic [15:0] kp_cnt;
    logic        overflow;
    logic        frame_done;
    logic [1:0]  fsm_state;

    int n_pass;
    int n_total;
    int n_fail;
    logic [34:0] exp_q[$];

    kp_collect #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH(DEPTH), .THR(3)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .octave(octave),
        .pix_vld(pix_vld), .kp_flag(kp_flag), .kp_max(kp_max), .kp_min(kp_min),
        .kp_ready(kp_ready), .kp_valid(kp_valid), .kp_x(kp_x), .kp_y(kp_y),
        .kp_oct(kp_oct), .kp_vmax(kp_vmax), .kp_vmin(kp_vmin), .fifo_lvl(fifo_lvl),
        .kp_cnt(kp_cnt), .overflow(overflow), .frame_done(frame_done), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] ent(input int x, input int y, input logic oct,
                                        input logic [7:0] mx, input logic [7:0] mn);
        return {9'(x), 9'(y), oct, mx, mn};
    endfunction

    function automatic logic [34:0] head();
        return {kp_x, kp_y, kp_oct, kp_vmax, kp_vmin};
    endfunction

    task automatic pix(input logic flag, input logic [7:0] mx, input logic [7:0] mn);
        pix_vld = 1'b1;
        kp_flag = flag;
        kp_max  = mx;
        kp_min  = mn;
        tick();
        pix_vld = 1'b0;
        kp_flag = 1'b0;
    endtask

    task automatic fstart(input logic oct);
        frame_start = 1'b1;
        octave      = oct;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            check({tag, "_valid"}, kp_valid, 1);
            check({tag, "_head"}, head(), exp_q[0]);
            kp_ready = 1'b1;
            tick();
            kp_ready = 1'b0;
            void'(exp_q.pop_front());
            guard++;
        end
        check({tag, "_empty_valid"}, kp_valid, 0);
        check({tag, "_empty_lvl"}, fifo_lvl, 0);
    endtask

    initial begin
        int p;
        int cyc;
        int cnt_m;
        logic ovf_m;
        logic do_pop;
        logic prev_stall;
        logic [34:0] prev_head;
        logic [7:0] rmx;
        logic [7:0] rmn;

        n_pass = 0; n_total = 0; n_fail = 0;
        rst = 1'b0; frame_start = 1'b0; octave = 1'b0; pix_vld = 1'b0;
        kp_flag = 1'b0; kp_max = '0; kp_min = '0; kp_ready = 1'b0;

        // T1a: reset state, then pixels before any frame_start are ignored
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", kp_valid, 0);
        check("rst_lvl", fifo_lvl, 0);
        check("rst_cnt", kp_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", frame_done, 0);
        check("rst_head", head(), 0);
        check("rst_state", fsm_state, 0);
        rst = 1'b1;
        tick();
        pix(1'b1, 8'h10, 8'hF0);
        pix(1'b1, 8'h11, 8'hF1);
        check("pre_fs_lvl", fifo_lvl, 0);
        check("pre_fs_valid", kp_valid, 0);
        check("pre_fs_cnt", kp_cnt, 0);

        // T2: octave 1 raster is 8x8; pixel 19 sits at (3,2)
        fstart(1'b1);
        check("t2_state_scan", fsm_state, 1);
        for (int i = 0; i < 64; i++) begin
            pix(i == 19, 8'h05, 8'hF9);
            if (i == 19) begin
                check("t2_valid", kp_valid, 1);
                check("t2_head", head(), ent(3, 2, 1'b1, 8'h05, 8'hF9));
                check("t2_lvl", fifo_lvl, 1);
            end
            if (i == 62) check("t2_done_early", frame_done, 0);
            if (i == 63) begin
                check("t2_done", frame_done, 1);
                check("t2_state_done", fsm_state, 2);
            end
        end
        tick();
        check("t2_done_pulse", frame_done, 0);
        check("t2_state_idle", fsm_state, 0);
        pix(1'b1, 8'h22, 8'h33);
        check("t2_idle_lvl", fifo_lvl, 1);
        check("t2_cnt", kp_cnt, 1);
        exp_q.push_back(ent(3, 2, 1'b1, 8'h05, 8'hF9));
        drain("t2_drain");

        // T3: 20 flagged pixels into a stalled 16-deep FIFO
        fstart(1'b0);
        for (int i = 0; i < 20; i++) begin
            pix(1'b1, 8'(i), 8'(-i));
            if (i < 16) exp_q.push_back(ent(i, 0, 1'b0, 8'(i), 8'(-i)));
        end
        check("t3_lvl", fifo_lvl, 16);
        check("t3_cnt", kp_cnt, 16);
        check("t3_ovf", overflow, 1);
        check("t3_head", head(), exp_q[0]);

        // T4: new frame keeps FIFO contents; push while full with a pop is accepted
        fstart(1'b0);
        check("t4_fs_ovf", overflow, 0);
        check("t4_fs_cnt", kp_cnt, 0);
        check("t4_fs_lvl", fifo_lvl, 16);
        check("t4_head_before", head(), exp_q[0]);
        kp_ready = 1'b1;
        pix(1'b1, 8'h55, 8'h80);
        kp_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(ent(0, 0, 1'b0, 8'h55, 8'h80));
        check("t4_lvl", fifo_lvl, 16);
        check("t4_ovf", overflow, 0);
        check("t4_cnt", kp_cnt, 1);
        check("t4_head_after", head(), exp_q[0]);
        drain("t3_drain");

        // T5: random strobes and random backpressure against a queue model
        fstart(1'b0);
        p = 0; cyc = 0; cnt_m = 0; ovf_m = 1'b0; prev_stall = 1'b0; prev_head = '0;
        while (p < 200 && cyc < 3000) begin
            pix_vld  = 1'($urandom_range(0, 1));
            kp_flag  = 1'b1;
            rmx      = 8'($urandom_range(0, 255));
            rmn      = 8'($urandom_range(0, 255));
            kp_max   = rmx;
            kp_min   = rmn;
            kp_ready = 1'($urandom_range(0, 1));
            check("t5_valid", kp_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("t5_head", head(), exp_q[0]);
            if (prev_stall) check("t5_stable", head(), prev_head);
            do_pop = (exp_q.size() != 0) && kp_ready;
            if (pix_vld) begin
                if (exp_q.size() < DEPTH || do_pop) begin
                    exp_q.push_back(ent(p % IMG_W, p / IMG_W, 1'b0, rmx, rmn));
                    cnt_m++;
                end else begin
                    ovf_m = 1'b1;
                end
                p++;
            end
            if (do_pop) void'(exp_q.pop_front());
            prev_stall = kp_valid && !kp_ready;
            prev_head  = head();
            tick();
            cyc++;
        end
        pix_vld = 1'b0; kp_flag = 1'b0; kp_ready = 1'b0;
        check("t5_finished", p, 200);
        check("t5_cnt", kp_cnt, cnt_m);
        check("t5_ovf", overflow, ovf_m);
        check("t5_lvl", fifo_lvl, exp_q.size());
        drain("t5_drain");

        // T6: contrast threshold boundaries (THR=3)
        fstart(1'b0);
        pix(1'b1, 8'h03, 8'hFE);
        pix(1'b1, 8'h04, 8'h00);
        pix(1'b1, 8'h00, 8'hFC);
        pix(1'b1, 8'h03, 8'hFD);
`ifdef KP_THR_EN
        exp_q.push_back(ent(1, 0, 1'b0, 8'h04, 8'h00));
        exp_q.push_back(ent(2, 0, 1'b0, 8'h00, 8'hFC));
`else
        exp_q.push_back(ent(0, 0, 1'b0, 8'h03, 8'hFE));
        exp_q.push_back(ent(1, 0, 1'b0, 8'h04, 8'h00));
        exp_q.push_back(ent(2, 0, 1'b0, 8'h00, 8'hFC));
        exp_q.push_back(ent(3, 0, 1'b0, 8'h03, 8'hFD));
`endif
        check("t6_lvl", fifo_lvl, exp_q.size());
        check("t6_cnt", kp_cnt, exp_q.size());
        check("t6_ovf", overflow, 0);
        drain("t6_drain");

        // T1b: asynchronous reset in the middle of a frame
        fstart(1'b0);
        pix(1'b1, 8'h01, 8'h02);
        pix(1'b1, 8'h03, 8'h04);
        pix(1'b1, 8'h05, 8'h06);
        check("t1_pre_lvl", fifo_lvl, 3);
        pix_vld = 1'b1; kp_flag = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("t1_async_valid", kp_valid, 0);
        check("t1_async_lvl", fifo_lvl, 0);
        check("t1_async_cnt", kp_cnt, 0);
        check("t1_async_head", head(), 0);
        check("t1_async_state", fsm_state, 0);
        pix_vld = 1'b0; kp_flag = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pix(1'b1, 8'h07, 8'h08);
        pix(1'b1, 8'h09, 8'h0A);
        check("t1_post_lvl", fifo_lvl, 0);
        check("t1_post_valid", kp_valid, 0);
        check("t1_post_cnt", kp_cnt, 0);
        check("t1_post_state", fsm_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
